dm_bus_adapter: RTL and testbench
=================================

DM_BUS_ADAPTER -- requirements
Module: dm_bus_adapter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, cycles the block waits in any request/response state before aborting with an error.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: dataBusAddr  in  32  byte address from the data memory interface.
REQ-005 Port: dataBusWriteData  in  32  store data, LSB-aligned (byte 0 = bits 7:0).
REQ-006 Port: dataBusWriteMask  in  4  byte enables, LSB-aligned: 0001 byte, 0011 halfword, 1111 word.
REQ-007 Port: dataBusWriteEn / dataBusReadEn  in  1 each  store / load request; never both high at once.
REQ-008 Port: dataBusReadData  out  32  load data, LSB-aligned, valid only in the DONE cycle.
REQ-009 Port: dataBusStall  out  1  core must hold all request inputs stable while high.
REQ-010 Port: dataBusError  out  1  access failed (timeout or rejected misalignment), valid only in the DONE cycle.
REQ-011 Port: memReq, memWe  out  1 each  memory request and write flag.
REQ-012 Port: memAddr  out  32  word-aligned address; bits 1:0 always 00.
REQ-013 Port: memWdata, memBe  out  32, 4  lane-positioned write data and byte enables.
REQ-014 Port: memGnt  in  1  request accepted in the cycle memReq && memGnt.
REQ-015 Port: memRvalid, memRdata  in  1, 32  response strobe (reads and writes) and lane-positioned read data.

Function
REQ-016 FSM states: IDLE, REQ1, RESP1, REQ2, RESP2, DONE.
REQ-017 IDLE -> REQ1 when dataBusReadEn or dataBusWriteEn is high; request fields are latched on this edge.
REQ-018 Lane shift: shifted mask = mask << addr[1:0] (7 bits); shifted data = wdata << 8*addr[1:0] (56 bits).
REQ-019 Access crosses a word when shifted-mask bits 6:4 are nonzero; otherwise it is a single word access.
REQ-020 REQ1: memReq=1, memAddr={addr[31:2],00}, memBe=shifted mask[3:0], memWdata=shifted data[31:0]; go to RESP1 on memGnt.
REQ-021 RESP1 -> DONE on memRvalid for a single access; RESP1 -> REQ2 on memRvalid for a crossing access.
REQ-022 In RESP1 of a load, memRdata is captured and shifted right by 8*addr[1:0].
REQ-023 REQ2: memAddr=first word address+4 (32-bit wrap from FFFFFFFC to 00000000), memBe={0,shifted mask[6:4]}, memWdata={8'b0,shifted data[55:32]}; go to RESP2 on memGnt.
REQ-024 In RESP2, memRdata bytes fill the upper load bytes not supplied by the first word; -> DONE on memRvalid.
REQ-025 Load data: byte-masked by the request mask; unrequested bytes are 0 (sign extension is done upstream).
REQ-026 DONE lasts exactly one cycle, then always -> IDLE; a new request is accepted no earlier than that IDLE cycle.
REQ-027 dataBusStall = (dataBusReadEn | dataBusWriteEn) && state != DONE (combinational).
REQ-028 Minimum single-access latency: request seen in cycle 0, memReq cycle 1, DONE cycle 3 when memGnt is immediate and memRvalid arrives 1 cycle after grant.
REQ-029 A timeout counter clears on every state entry and increments in REQ1/RESP1/REQ2/RESP2.
REQ-030 Counter == TIMEOUT_CYCLES-1 without the exiting event -> DONE with dataBusError=1 and dataBusReadData=0.
REQ-031 memRvalid outside RESP1/RESP2 and memGnt outside REQ1/REQ2 are ignored.
REQ-032 memReq is high only in REQ1/REQ2; memWe is the latched write flag while memReq is high, else 0.

Reset
REQ-033 On rst: state=IDLE, counter=0, latched fields=0; memReq, memWe, memBe, memWdata, memAddr, dataBusReadData and dataBusError all 0.
REQ-034 Reset mid-transaction abandons it immediately; no second access is issued after reset release.

Configuration
REQ-035 Macro DM_MISALIGN_SPLIT_EN defined: word-crossing accesses split per REQ-021..REQ-024.
REQ-036 Macro DM_MISALIGN_SPLIT_EN undefined: a crossing access goes IDLE -> REQ1 -> DONE with memReq never asserted and dataBusError=1; REQ2/RESP2 are not built.

Verification
REQ-037 Load word at 0x100, mask 1111, memRdata=0xDEADBEEF, 0-wait grant -> dataBusReadData=0xDEADBEEF in DONE, error 0, DONE at cycle 3.
REQ-038 Store byte 0xA5 at 0x203 -> memAddr=0x200, memBe=1000, memWdata[31:24]=0xA5, single access.
REQ-039 Split on: load word at 0x102, word 0x100=0x44332211, word 0x104=0x88776655 -> memAddr 0x100 then 0x104, memBe 1100 then 0011, rdata=0x66554433.
REQ-040 Split off: halfword store at 0x103 -> no memReq, DONE with error=1.
REQ-041 memGnt held low for 16 cycles -> DONE with error=1, rdata=0, then IDLE.
REQ-042 rst asserted in RESP1 of a split load -> all outputs 0 the same cycle; the 0x104 access never issues.

Source files
------------

// File: rtl/dm_bus_adapter.sv
// Data-memory bus adapter: maps LSB-aligned core loads/stores onto a word-aligned req/gnt/rvalid memory port.
// Optional macro DM_MISALIGN_SPLIT_EN splits word-crossing accesses into two memory transactions.
module dm_bus_adapter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataBusAddr,
    input  logic [31:0] dataBusWriteData,
    input  logic [3:0]  dataBusWriteMask,
    input  logic        dataBusWriteEn,
    input  logic        dataBusReadEn,
    output logic [31:0] dataBusReadData,
    output logic        dataBusStall,
    output logic        dataBusError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        RESP1 = 3'd2,
        REQ2  = 3'd3,
        RESP2 = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [6:0] shiftMask(input logic [3:0] mask, input logic [1:0] off);
        shiftMask = {3'b000, mask} << off;
    endfunction

    function automatic logic [55:0] shiftData(input logic [31:0] data, input logic [1:0] off);
        shiftData = {24'h000000, data} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] alignRead(input logic [63:0] raw, input logic [1:0] off);
        logic [63:0] sh;
        sh        = raw >> {off, 3'b000};
        alignRead = sh[31:0];
    endfunction

    function automatic logic [31:0] byteMask(input logic [31:0] data, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            byteMask[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
        end
    endfunction

    state_t        state_r, nextState_s;
    logic [CW-1:0] cnt_r;
    logic [31:0]   latAddr_r, latData_r;
    logic [3:0]    latMask_r;
    logic          latWe_r;

    logic [31:0]   effAddr_s, effData_s;
    logic [3:0]    effMask_s;
    logic          effWe_s;
    logic [6:0]    shMask_s;
    logic [55:0]   shData_s;
    logic          crossing_s, rejectCross_s, splitCross_s, timeout_s;
    logic [31:0]   firstAddr_s, secondAddr_s;
    logic          errNext_s;
    logic [63:0]   rawNext_s;
    logic          reqNext_s;
    logic [31:0]   addrNext_s, wdataNext_s, rdNext_s;
    logic [3:0]    beNext_s;

    logic          memReq_r, memWe_r, dataBusError_r;
    logic [31:0]   memAddr_r, memWdata_r, dataBusReadData_r;
    logic [3:0]    memBe_r;

`ifdef DM_MISALIGN_SPLIT_EN
    logic [31:0]   rawLo_r;
`endif

    // Request fields come straight from the core in IDLE (latch edge), otherwise from the latch.
    always_comb begin
        if (state_r == IDLE) begin
            effAddr_s = dataBusAddr;
            effData_s = dataBusWriteData;
            effMask_s = dataBusWriteMask;
            effWe_s   = dataBusWriteEn;
        end else begin
            effAddr_s = latAddr_r;
            effData_s = latData_r;
            effMask_s = latMask_r;
            effWe_s   = latWe_r;
        end
    end

    assign shMask_s     = shiftMask(effMask_s, effAddr_s[1:0]);
    assign shData_s     = shiftData(effData_s, effAddr_s[1:0]);
    assign crossing_s   = |shMask_s[6:4];
    assign firstAddr_s  = {effAddr_s[31:2], 2'b00};
    assign secondAddr_s = firstAddr_s + 32'd4;
    assign timeout_s    = (cnt_r == CNT_LAST);
`ifdef DM_MISALIGN_SPLIT_EN
    assign rejectCross_s = 1'b0;
    assign splitCross_s  = crossing_s;
`else
    assign rejectCross_s = crossing_s;
    assign splitCross_s  = 1'b0;
`endif

    // Next-state logic; rawNext_s carries the unshifted response word(s) into DONE.
    always_comb begin
        nextState_s = state_r;
        errNext_s   = 1'b0;
        rawNext_s   = 64'h0;
        case (state_r)
            IDLE: begin
                if (dataBusReadEn || dataBusWriteEn) begin
                    nextState_s = REQ1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ1: begin
                if (rejectCross_s) begin
                    nextState_s = DONE;
                    errNext_s   = 1'b1;
                end else if (memGnt) begin
                    nextState_s = RESP1;
                end else if (timeout_s) begin
                    nextState_s = DONE;
                    errNext_s   = 1'b1;
                end else begin
                    nextState_s = REQ1;
                end
            end
            RESP1: begin
                if (memRvalid) begin
                    nextState_s = splitCross_s ? REQ2 : DONE;
                    rawNext_s   = {32'h0, memRdata};
                end else if (timeout_s) begin
                    nextState_s = DONE;
                    errNext_s   = 1'b1;
                end else begin
                    nextState_s = RESP1;
                end
            end
`ifdef DM_MISALIGN_SPLIT_EN
            REQ2: begin
                if (memGnt) begin
                    nextState_s = RESP2;
                end else if (timeout_s) begin
                    nextState_s = DONE;
                    errNext_s   = 1'b1;
                end else begin
                    nextState_s = REQ2;
                end
            end
            RESP2: begin
                if (memRvalid) begin
                    nextState_s = DONE;
                    rawNext_s   = {memRdata, rawLo_r};
                end else if (timeout_s) begin
                    nextState_s = DONE;
                    errNext_s   = 1'b1;
                end else begin
                    nextState_s = RESP2;
                end
            end
`endif
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Memory-side values for the state being entered, so the port is driven from flops.
    always_comb begin
        reqNext_s   = 1'b0;
        addrNext_s  = 32'h0;
        beNext_s    = 4'h0;
        wdataNext_s = 32'h0;
        case (nextState_s)
            REQ1: begin
                if (!rejectCross_s) begin
                    reqNext_s   = 1'b1;
                    addrNext_s  = firstAddr_s;
                    beNext_s    = shMask_s[3:0];
                    wdataNext_s = shData_s[31:0];
                end else begin
                    reqNext_s   = 1'b0;
                end
            end
            REQ2: begin
                reqNext_s   = 1'b1;
                addrNext_s  = secondAddr_s;
                beNext_s    = {1'b0, shMask_s[6:4]};
                wdataNext_s = {8'h00, shData_s[55:32]};
            end
            default: reqNext_s = 1'b0;
        endcase
    end

    // Load result for DONE: zero on error or store, otherwise aligned and byte-masked.
    always_comb begin
        if ((nextState_s == DONE) && !errNext_s && !effWe_s) begin
            rdNext_s = byteMask(alignRead(rawNext_s, effAddr_s[1:0]), effMask_s);
        end else begin
            rdNext_s = 32'h0;
        end
    end

    // State register, timeout counter and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            latAddr_r <= 32'h0;
            latData_r <= 32'h0;
            latMask_r <= 4'h0;
            latWe_r   <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if ((nextState_s != state_r) || (state_r == IDLE) || (state_r == DONE)) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if ((state_r == IDLE) && (nextState_s == REQ1)) begin
                latAddr_r <= dataBusAddr;
                latData_r <= dataBusWriteData;
                latMask_r <= dataBusWriteMask;
                latWe_r   <= dataBusWriteEn;
            end else begin
                latAddr_r <= latAddr_r;
                latData_r <= latData_r;
                latMask_r <= latMask_r;
                latWe_r   <= latWe_r;
            end
        end
    end

`ifdef DM_MISALIGN_SPLIT_EN
    // First response word of a split load, needed when the second word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rawLo_r <= 32'h0;
        end else if ((state_r == RESP1) && memRvalid) begin
            rawLo_r <= memRdata;
        end else begin
            rawLo_r <= rawLo_r;
        end
    end
`endif

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq_r          <= 1'b0;
            memWe_r           <= 1'b0;
            memAddr_r         <= 32'h0;
            memBe_r           <= 4'h0;
            memWdata_r        <= 32'h0;
            dataBusReadData_r <= 32'h0;
            dataBusError_r    <= 1'b0;
        end else begin
            memReq_r          <= reqNext_s;
            memWe_r           <= reqNext_s & effWe_s;
            memAddr_r         <= addrNext_s;
            memBe_r           <= beNext_s;
            memWdata_r        <= wdataNext_s;
            dataBusReadData_r <= rdNext_s;
            dataBusError_r    <= (nextState_s == DONE) & errNext_s;
        end
    end

    assign memReq          = memReq_r;
    assign memWe           = memWe_r;
    assign memAddr         = memAddr_r;
    assign memBe           = memBe_r;
    assign memWdata        = memWdata_r;
    assign dataBusReadData = dataBusReadData_r;
    assign dataBusError    = dataBusError_r;
    assign dataBusStall    = (dataBusReadEn | dataBusWriteEn) && (state_r != DONE);

endmodule

// File: tb/tb_dm_bus_adapter.sv
// Directed testbench for dm_bus_adapter: 0-wait memory responder, access log and per-scenario tasks.
module tb_dm_bus_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataBusAddr = 32'h0;
    logic [31:0] dataBusWriteData = 32'h0;
    logic [3:0]  dataBusWriteMask = 4'h0;
    logic        dataBusWriteEn = 1'b0;
    logic        dataBusReadEn = 1'b0;
    logic [31:0] dataBusReadData;
    logic        dataBusStall;
    logic        dataBusError;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memBe;
    logic        memGnt;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = 32'h0;

    logic        gntEnable = 1'b1;
    logic [31:0] memArr [0:255];
    logic [31:0] logAddr[$];
    logic [31:0] logWdata[$];
    logic [3:0]  logBe[$];
    logic        logWe[$];
    int          reqCount = 0;

    int passCnt = 0;
    int totalCnt = 0;

    dm_bus_adapter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .dataBusAddr(dataBusAddr), .dataBusWriteData(dataBusWriteData),
        .dataBusWriteMask(dataBusWriteMask), .dataBusWriteEn(dataBusWriteEn),
        .dataBusReadEn(dataBusReadEn), .dataBusReadData(dataBusReadData),
        .dataBusStall(dataBusStall), .dataBusError(dataBusError),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memBe(memBe), .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    assign memGnt = memReq & gntEnable;

    // Memory responder: response one cycle after grant, plus an access log.
    always @(posedge clk) begin
        memRvalid <= memReq & memGnt;
        memRdata  <= memArr[memAddr[9:2]];
        if (memReq) reqCount <= reqCount + 1;
        if (memReq && memGnt) begin
            logAddr.push_back(memAddr);
            logWdata.push_back(memWdata);
            logBe.push_back(memBe);
            logWe.push_back(memWe);
        end
    end

    task automatic doAccess(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [3:0] mask, output logic [31:0] rdata,
                            output logic err, output int cyc);
        logic done;
        done = 1'b0; cyc = 0; rdata = 32'hx; err = 1'bx;
        @(posedge clk); #1;
        dataBusAddr = addr; dataBusWriteData = wdata; dataBusWriteMask = mask;
        dataBusWriteEn = we; dataBusReadEn = ~we;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!dataBusStall) begin
                done = 1'b1; rdata = dataBusReadData; err = dataBusError;
            end else begin
                @(posedge clk); cyc++;
            end
        end
        totalCnt++;
        if (!done) $display("FAIL access_done addr=%h: no DONE within 40 cycles, required DONE", addr);
        else passCnt++;
        @(posedge clk); #1;
        dataBusWriteEn = 1'b0; dataBusReadEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        totalCnt++; if (memReq !== 1'b0) $display("FAIL rst_memReq got %b need 0", memReq); else passCnt++;
        totalCnt++; if (memWe !== 1'b0) $display("FAIL rst_memWe got %b need 0", memWe); else passCnt++;
        totalCnt++; if (memAddr !== 32'h0) $display("FAIL rst_memAddr got %h need 0", memAddr); else passCnt++;
        totalCnt++; if (memBe !== 4'h0) $display("FAIL rst_memBe got %b need 0", memBe); else passCnt++;
        totalCnt++; if (memWdata !== 32'h0) $display("FAIL rst_memWdata got %h need 0", memWdata); else passCnt++;
        totalCnt++; if (dataBusReadData !== 32'h0) $display("FAIL rst_rdata got %h need 0", dataBusReadData); else passCnt++;
        totalCnt++; if (dataBusError !== 1'b0) $display("FAIL rst_error got %b need 0", dataBusError); else passCnt++;
        totalCnt++; if (dataBusStall !== 1'b0) $display("FAIL rst_stall got %b need 0", dataBusStall); else passCnt++;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_load_word();
        logic [31:0] rd; logic er; int cyc; int base;
        memArr[8'h40] = 32'hDEADBEEF;
        base = logAddr.size();
        doAccess(32'h100, 1'b0, 32'h0, 4'b1111, rd, er, cyc);
        totalCnt++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h need DEADBEEF", rd); else passCnt++;
        totalCnt++; if (er !== 1'b0) $display("FAIL lw_error got %b need 0", er); else passCnt++;
        totalCnt++; if (cyc != 3) $display("FAIL lw_latency got %0d need 3", cyc); else passCnt++;
        totalCnt++;
        if (logAddr.size() != base + 1) $display("FAIL lw_count got %0d need 1", logAddr.size() - base);
        else if (logAddr[base] !== 32'h100 || logBe[base] !== 4'b1111 || logWe[base] !== 1'b0)
            $display("FAIL lw_access got addr=%h be=%b we=%b need 100/1111/0", logAddr[base], logBe[base], logWe[base]);
        else passCnt++;
    endtask

    task automatic test_store_byte();
        logic [31:0] rd; logic er; int cyc; int base;
        base = logAddr.size();
        doAccess(32'h203, 1'b1, 32'h000000A5, 4'b0001, rd, er, cyc);
        totalCnt++; if (er !== 1'b0) $display("FAIL sb_error got %b need 0", er); else passCnt++;
        totalCnt++; if (rd !== 32'h0) $display("FAIL sb_rdata got %h need 0", rd); else passCnt++;
        totalCnt++; if (cyc != 3) $display("FAIL sb_latency got %0d need 3", cyc); else passCnt++;
        totalCnt++;
        if (logAddr.size() != base + 1) $display("FAIL sb_count got %0d need 1", logAddr.size() - base);
        else if (logAddr[base] !== 32'h200 || logBe[base] !== 4'b1000 ||
                 logWdata[base] !== 32'hA5000000 || logWe[base] !== 1'b1)
            $display("FAIL sb_access got addr=%h be=%b wd=%h we=%b need 200/1000/A5000000/1",
                     logAddr[base], logBe[base], logWdata[base], logWe[base]);
        else passCnt++;
    endtask

    task automatic test_subword_loads();
        logic [31:0] rd; logic er; int cyc; int base;
        memArr[8'h40] = 32'h44332211;
        base = logAddr.size();
        doAccess(32'h102, 1'b0, 32'h0, 4'b0011, rd, er, cyc);
        totalCnt++; if (rd !== 32'h00004433) $display("FAIL lh_rdata got %h need 00004433", rd); else passCnt++;
        totalCnt++;
        if (logAddr.size() != base + 1 || logBe[base] !== 4'b1100)
            $display("FAIL lh_access got count=%0d need 1 with be 1100", logAddr.size() - base);
        else passCnt++;
        doAccess(32'h101, 1'b0, 32'h0, 4'b0001, rd, er, cyc);
        totalCnt++; if (rd !== 32'h00000022) $display("FAIL lb_rdata got %h need 00000022", rd); else passCnt++;
        totalCnt++; if (er !== 1'b0) $display("FAIL lb_error got %b need 0", er); else passCnt++;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int cyc; int base;
        memArr[8'h40] = 32'h12345678;
        base = logAddr.size();
        gntEnable = 1'b0;
        doAccess(32'h100, 1'b0, 32'h0, 4'b1111, rd, er, cyc);
        totalCnt++; if (er !== 1'b1) $display("FAIL to_error got %b need 1", er); else passCnt++;
        totalCnt++; if (rd !== 32'h0) $display("FAIL to_rdata got %h need 0", rd); else passCnt++;
        totalCnt++; if (cyc != 17) $display("FAIL to_latency got %0d need 17", cyc); else passCnt++;
        totalCnt++; if (logAddr.size() != base) $display("FAIL to_count got %0d need 0", logAddr.size() - base); else passCnt++;
        totalCnt++;
        if (memReq !== 1'b0 || dataBusError !== 1'b0)
            $display("FAIL to_idle got memReq=%b err=%b need 0/0", memReq, dataBusError);
        else passCnt++;
        gntEnable = 1'b1;
    endtask

`ifdef DM_MISALIGN_SPLIT_EN
    task automatic test_split();
        logic [31:0] rd; logic er; int cyc; int base;
        memArr[8'h40] = 32'h44332211;
        memArr[8'h41] = 32'h88776655;
        base = logAddr.size();
        doAccess(32'h102, 1'b0, 32'h0, 4'b1111, rd, er, cyc);
        totalCnt++; if (rd !== 32'h66554433) $display("FAIL split_rdata got %h need 66554433", rd); else passCnt++;
        totalCnt++; if (er !== 1'b0) $display("FAIL split_error got %b need 0", er); else passCnt++;
        totalCnt++; if (cyc != 5) $display("FAIL split_latency got %0d need 5", cyc); else passCnt++;
        totalCnt++;
        if (logAddr.size() != base + 2) $display("FAIL split_count got %0d need 2", logAddr.size() - base);
        else if (logAddr[base] !== 32'h100 || logBe[base] !== 4'b1100 ||
                 logAddr[base+1] !== 32'h104 || logBe[base+1] !== 4'b0011)
            $display("FAIL split_access got %h/%b %h/%b need 100/1100 104/0011",
                     logAddr[base], logBe[base], logAddr[base+1], logBe[base+1]);
        else passCnt++;
        base = logAddr.size();
        doAccess(32'hFFFFFFFF, 1'b1, 32'h0000BEEF, 4'b0011, rd, er, cyc);
        totalCnt++;
        if (logAddr.size() != base + 2) $display("FAIL wrap_count got %0d need 2", logAddr.size() - base);
        else if (logAddr[base] !== 32'hFFFFFFFC || logBe[base] !== 4'b1000 || logWdata[base] !== 32'hEF000000 ||
                 logAddr[base+1] !== 32'h0 || logBe[base+1] !== 4'b0001 || logWdata[base+1] !== 32'h000000BE)
            $display("FAIL wrap_access got %h/%b/%h %h/%b/%h need FFFFFFFC/1000/EF000000 0/0001/BE",
                     logAddr[base], logBe[base], logWdata[base], logAddr[base+1], logBe[base+1], logWdata[base+1]);
        else passCnt++;
    endtask
`else
    task automatic test_split();
        logic [31:0] rd; logic er; int cyc; int snap;
        snap = reqCount;
        doAccess(32'h103, 1'b1, 32'h0000BEEF, 4'b0011, rd, er, cyc);
        totalCnt++; if (er !== 1'b1) $display("FAIL nosplit_error got %b need 1", er); else passCnt++;
        totalCnt++; if (cyc != 2) $display("FAIL nosplit_latency got %0d need 2", cyc); else passCnt++;
        totalCnt++; if (reqCount != snap) $display("FAIL nosplit_memReq got %0d req cycles need 0", reqCount - snap); else passCnt++;
    endtask
`endif

    task automatic test_reset_mid();
        int base; int snap;
        memArr[8'h40] = 32'h44332211;
        base = logAddr.size();
        @(posedge clk); #1;
`ifdef DM_MISALIGN_SPLIT_EN
        dataBusAddr = 32'h102;
`else
        dataBusAddr = 32'h100;
`endif
        dataBusWriteMask = 4'b1111; dataBusReadEn = 1'b1; dataBusWriteEn = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; dataBusReadEn = 1'b0;
        #1;
        totalCnt++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || memAddr !== 32'h0 || memBe !== 4'h0 || memWdata !== 32'h0 ||
            dataBusReadData !== 32'h0 || dataBusError !== 1'b0)
            $display("FAIL midrst_outputs got req=%b we=%b addr=%h be=%b wd=%h rd=%h err=%b need all 0",
                     memReq, memWe, memAddr, memBe, memWdata, dataBusReadData, dataBusError);
        else passCnt++;
        totalCnt++; if (logAddr.size() != base + 1) $display("FAIL midrst_first got %0d need 1", logAddr.size() - base); else passCnt++;
        @(posedge clk); #1; rst = 1'b0;
        snap = reqCount;
        repeat (8) @(posedge clk);
        #1;
        totalCnt++; if (reqCount != snap) $display("FAIL midrst_noreq got %0d req cycles need 0", reqCount - snap); else passCnt++;
        totalCnt++; if (logAddr.size() != base + 1) $display("FAIL midrst_count got %0d need 1", logAddr.size() - base); else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cyc;
        memArr[8'h50] = 32'hCAFEF00D;
        memArr[8'h51] = 32'h01020304;
        doAccess(32'h140, 1'b0, 32'h0, 4'b1111, rd, er, cyc);
        totalCnt++; if (rd !== 32'hCAFEF00D) $display("FAIL b2b_first got %h need CAFEF00D", rd); else passCnt++;
        doAccess(32'h146, 1'b0, 32'h0, 4'b0011, rd, er, cyc);
        totalCnt++; if (rd !== 32'h00000102) $display("FAIL b2b_second got %h need 00000102", rd); else passCnt++;
        totalCnt++; if (cyc != 3) $display("FAIL b2b_latency got %0d need 3", cyc); else passCnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
        test_reset();
        test_load_word();
        test_store_byte();
        test_subword_loads();
        test_timeout();
        test_split();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
